// File: rtl/mod_exp_ctrl_pkg.sv
// Shared opcodes, FSM states and address maps for the square-and-multiply sequencer.
package mod_exp_ctrl_pkg;

  typedef enum logic [1:0] {
    OPXX = 2'd0,
    OPXM = 2'd1,
    OPX1 = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ_I,
    S_SQ_W,
    S_MUL_I,
    S_MUL_W,
    S_CONV_I,
    S_CONV_W,
    S_DONE
  } state_e;

  // Operand RAM word map (x_bar lives in words 0/1) and host-only modulus slots
  localparam logic [1:0] RAM_XBAR_LO = 2'd0;
  localparam logic [1:0] RAM_XBAR_HI = 2'd1;
  localparam logic [2:0] HOST_MOD_LO = 3'd4;
  localparam logic [2:0] HOST_MOD_HI = 3'd5;

  function automatic int bitlen(input int dbits);
    return 2 * dbits;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_opram.sv
// 4-word operand RAM: one registered read port, engine and host write ports (engine wins).
module mp_opram
  import mod_exp_ctrl_pkg::*;
#(
  parameter int DBITS = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         rd_addr,
  output logic [DBITS-1:0]   rd_data,
  input  logic               eng_wr_en,
  input  logic [1:0]         eng_wr_addr,
  input  logic [DBITS-1:0]   eng_wr_data,
  input  logic               host_wr_en,
  input  logic [1:0]         host_wr_addr,
  input  logic [DBITS-1:0]   host_wr_data,
  output logic [2*DBITS-1:0] x_bar
);

  logic [DBITS-1:0] mem [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
      if (host_wr_en) mem[host_wr_addr] <= host_wr_data;
      // Later assignment takes effect, so the engine overrides a colliding host write
      if (eng_wr_en) mem[eng_wr_addr] <= eng_wr_data;
    end
  end

  // x_bar as it will be after this edge, so the result capture sees a same-cycle engine write
  always_comb begin
    x_bar = {mem[RAM_XBAR_HI], mem[RAM_XBAR_LO]};
    if (eng_wr_en && eng_wr_addr == RAM_XBAR_LO) x_bar[DBITS-1:0] = eng_wr_data;
    if (eng_wr_en && eng_wr_addr == RAM_XBAR_HI) x_bar[2*DBITS-1:DBITS] = eng_wr_data;
  end

endmodule

// File: rtl/mod_exp_ctrl.sv
// Square-and-multiply sequencer driving the Montgomery product engine; returns x^e mod m.
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int ABITS    = 8,
  parameter int DBITS    = 512,
  parameter int EBITS    = 1024,
  parameter int ELW      = 11,
  parameter int MP_COUNT = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_en,
  input  logic [2:0]              ld_addr,
  input  logic [DBITS-1:0]        ld_data,
  input  logic [EBITS-1:0]        e,
  input  logic [ELW-1:0]          e_len,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [bitlen(DBITS)-1:0] result,
  output logic                    mp_start,
  output logic [1:0]              mp_op_code,
  output logic [9:0]              mp_count,
  output logic [bitlen(DBITS)-1:0] mp_M,
  input  logic                    mp_stop,
  input  logic [ABITS-1:0]        mp_rd_addr,
  output logic [DBITS-1:0]        mp_rd_data,
  input  logic                    mp_wr_en,
  input  logic [ABITS-1:0]        mp_wr_addr,
  input  logic [DBITS-1:0]        mp_wr_data
);

  localparam int IW = $clog2(EBITS);

  state_e                  state;
  op_e                     op_q;
  logic [EBITS-1:0]        e_q;
  logic [ELW-1:0]          idx;
  logic                    stop_q;
  logic                    fin;
  logic                    host_wr;
  logic [ELW-1:0]          len_sat;
  logic [2*DBITS-1:0]      x_bar;
  logic                    unused_addr_bits;

  assign fin              = mp_stop & ~stop_q;
  assign host_wr          = ld_en & ~busy;
  assign len_sat          = (e_len > ELW'(EBITS)) ? ELW'(EBITS) : e_len;
  assign mp_op_code       = op_q;
  assign unused_addr_bits = ^{mp_rd_addr[ABITS-1:2], mp_wr_addr[ABITS-1:2]};

  mp_opram #(.DBITS(DBITS)) u_opram (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_addr      (mp_rd_addr[1:0]),
    .rd_data      (mp_rd_data),
    .eng_wr_en    (mp_wr_en),
    .eng_wr_addr  (mp_wr_addr[1:0]),
    .eng_wr_data  (mp_wr_data),
    .host_wr_en   (host_wr & ~ld_addr[2]),
    .host_wr_addr (ld_addr[1:0]),
    .host_wr_data (ld_data),
    .x_bar        (x_bar)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OPXX;
      e_q      <= '0;
      idx      <= '0;
      stop_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mp_start <= 1'b0;
      mp_count <= '0;
      mp_M     <= '0;
    end else begin
      stop_q   <= mp_stop;
      mp_start <= 1'b0;
      done     <= 1'b0;
      mp_count <= 10'(MP_COUNT);
      if (host_wr && ld_addr == HOST_MOD_LO) mp_M[DBITS-1:0] <= ld_data;
      if (host_wr && ld_addr == HOST_MOD_HI) mp_M[2*DBITS-1:DBITS] <= ld_data;

      // idx is decremented on each square issue, so in the wait states it names the current bit
      case (state)
        S_IDLE: begin
          if (start) begin
            e_q   <= e;
            idx   <= len_sat;
            busy  <= 1'b1;
            state <= (len_sat == '0) ? S_CONV_I : S_SQ_I;
          end
        end
        S_SQ_I: begin
          mp_start <= 1'b1;
          op_q     <= OPXX;
          idx      <= idx - ELW'(1);
          state    <= S_SQ_W;
        end
        S_SQ_W: begin
          if (fin) begin
            if (e_q[idx[IW-1:0]]) state <= S_MUL_I;
            else                  state <= (idx == '0) ? S_CONV_I : S_SQ_I;
          end
        end
        S_MUL_I: begin
          mp_start <= 1'b1;
          op_q     <= OPXM;
          state    <= S_MUL_W;
        end
        S_MUL_W: begin
          if (fin) state <= (idx == '0) ? S_CONV_I : S_SQ_I;
        end
        S_CONV_I: begin
          mp_start <= 1'b1;
          op_q     <= OPX1;
          state    <= S_CONV_W;
        end
        S_CONV_W: begin
          if (fin) state <= S_DONE;
        end
        S_DONE: begin
          result <= x_bar;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Randomized bench for mod_exp_ctrl with a behavioural mon_prod engine and shadow RAM model.
module tb_mod_exp_ctrl;

  localparam int ABITS    = 8;
  localparam int DBITS    = 32;
  localparam int EBITS    = 16;
  localparam int ELW      = 5;
  localparam int MP_COUNT = 1023;
  localparam int LIMIT    = 2100;

  typedef enum int {M_XX = 0, M_XM = 1, M_X1 = 2} model_op_e;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ld_en = 1'b0;
  logic [2:0]         ld_addr = '0;
  logic [DBITS-1:0]   ld_data = '0;
  logic [EBITS-1:0]   e = '0;
  logic [ELW-1:0]     e_len = '0;
  logic               start = 1'b0;
  logic               busy, done, mp_start;
  logic [2*DBITS-1:0] result, mp_M;
  logic [1:0]         mp_op_code;
  logic [9:0]         mp_count;
  logic               mp_stop = 1'b0;
  logic [ABITS-1:0]   mp_rd_addr = '0;
  logic [DBITS-1:0]   mp_rd_data;
  logic               mp_wr_en = 1'b0;
  logic [ABITS-1:0]   mp_wr_addr = '0;
  logic [DBITS-1:0]   mp_wr_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int stop_cycle = 0;
  int ops[$];

  logic [DBITS-1:0]   shadow [4];
  logic [2*DBITS-1:0] shadow_m = '0;
  logic [2*DBITS-1:0] held_result = '0;
  logic [DBITS-1:0]   exp_rd;
  bit                 host_ok = 1'b1;
  bit                 rd_hold = 1'b0;
  logic [1:0]         rd_hold_val = '0;

  bit                 eng_active = 1'b0;
  int                 eng_cnt = 0;
  logic [1:0]         eng_op = '0;

  mod_exp_ctrl #(
    .ABITS(ABITS), .DBITS(DBITS), .EBITS(EBITS), .ELW(ELW), .MP_COUNT(MP_COUNT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .e          (e),
    .e_len      (e_len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mp_start   (mp_start),
    .mp_op_code (mp_op_code),
    .mp_count   (mp_count),
    .mp_M       (mp_M),
    .mp_stop    (mp_stop),
    .mp_rd_addr (mp_rd_addr),
    .mp_rd_data (mp_rd_data),
    .mp_wr_en   (mp_wr_en),
    .mp_wr_addr (mp_wr_addr),
    .mp_wr_data (mp_wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Behavioural engine: 50-cycle run, writes x_bar words 0 then 1, raises stop, clears it after next start
  always @(negedge clk) begin
    if (!rst_n) begin
      eng_active = 1'b0;
      eng_cnt    = 0;
      mp_stop    = 1'b0;
      mp_wr_en   = 1'b0;
    end else begin
      mp_wr_en = 1'b0;
      if (mp_start) begin
        ops.push_back(int'(mp_op_code));
        eng_op     = mp_op_code;
        eng_active = 1'b1;
        eng_cnt    = 0;
      end else if (eng_active) begin
        eng_cnt++;
        checkOutput("op_stable", 64'(mp_op_code), 64'(eng_op));
        if (eng_cnt == 2) mp_stop = 1'b0;
        if (eng_cnt == 47 || eng_cnt == 48) begin
          mp_wr_en   = 1'b1;
          mp_wr_addr = {6'($urandom), ((eng_cnt == 47) ? 2'd0 : 2'd1)};
          mp_wr_data = $urandom;
        end
        if (eng_cnt == 50) begin
          mp_stop    = 1'b1;
          stop_cycle = cycle;
          eng_active = 1'b0;
        end
      end
    end
    if (rd_hold)       mp_rd_addr = {6'($urandom), rd_hold_val};
    else if (mp_wr_en) mp_rd_addr = {6'($urandom), mp_wr_addr[1:0]};
    else               mp_rd_addr = 8'($urandom);
  end

  // Shadow RAM/modulus model and every-cycle output comparison
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) shadow[i] = '0;
      shadow_m    = '0;
      held_result = '0;
    end else begin
      exp_rd = shadow[mp_rd_addr[1:0]];
      if (ld_en && host_ok) begin
        if (!ld_addr[2])          shadow[ld_addr[1:0]] = ld_data;
        else if (ld_addr == 3'd4) shadow_m[DBITS-1:0] = ld_data;
        else if (ld_addr == 3'd5) shadow_m[2*DBITS-1:DBITS] = ld_data;
      end
      if (mp_wr_en) shadow[mp_wr_addr[1:0]] = mp_wr_data;
      #1;
      if (rst_n) begin
        if (done) held_result = {shadow[1], shadow[0]};
        checkOutput("rd_data", 64'(mp_rd_data), 64'(exp_rd));
        checkOutput("mp_M", mp_M, shadow_m);
        checkOutput("result", result, held_result);
        checkOutput("mp_count", 64'(mp_count), 64'(MP_COUNT));
        checkOutput("done_with_busy", 64'(done & busy), 64'd0);
        if (mp_start) checkOutput("start_busy", 64'(busy), 64'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] addr, input logic [DBITS-1:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic loadRandom();
    for (int a = 0; a < 6; a++) applyStimulus(3'(a), $urandom);
  endtask

  task automatic readWord(input logic [1:0] a, input logic [DBITS-1:0] exp, input string name);
    rd_hold_val = a;
    rd_hold     = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput(name, 64'(mp_rd_data), 64'(exp));
    rd_hold     = 1'b0;
  endtask

  task automatic checkZeros(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_result"}, result, 64'd0);
    checkOutput({tag, "_mp_start"}, 64'(mp_start), 64'd0);
    checkOutput({tag, "_op"}, 64'(mp_op_code), 64'd0);
    checkOutput({tag, "_count"}, 64'(mp_count), 64'd0);
    checkOutput({tag, "_mp_M"}, mp_M, 64'd0);
    checkOutput({tag, "_rd_data"}, 64'(mp_rd_data), 64'd0);
  endtask

  task automatic runExp(input logic [EBITS-1:0] ev, input int lv, input bit inject);
    int exp_ops[$];
    int len;
    int cyc;
    bit busy_ok;
    len = (lv > EBITS) ? EBITS : lv;
    for (int i = len - 1; i >= 0; i--) begin
      exp_ops.push_back(M_XX);
      if (ev[i]) exp_ops.push_back(M_XM);
    end
    exp_ops.push_back(M_X1);
    ops.delete();
    @(negedge clk);
    e     = ev;
    e_len = ELW'(lv);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc     = 0;
    busy_ok = 1'b1;
    while (!done && cyc < LIMIT) begin
      if (!busy) busy_ok = 1'b0;
      if (inject && cyc == 40) begin
        start   = 1'b1;
        ld_en   = 1'b1;
        ld_addr = 3'($urandom_range(0, 5));
        ld_data = $urandom;
        host_ok = 1'b0;
      end else begin
        start = 1'b0;
        ld_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    ld_en   = 1'b0;
    host_ok = 1'b1;
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("busy_during_run", 64'(busy_ok), 64'd1);
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    checkOutput("done_latency", 64'(cycle - stop_cycle), 64'd2);
    checkOutput("op_count", 64'(ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < ops.size() && i < exp_ops.size(); i++)
      checkOutput($sformatf("op%0d", i), 64'(ops[i]), 64'(exp_ops[i]));
    @(negedge clk);
    checkOutput("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    int lit1[6];
    int cyc;
    lit1 = '{0, 1, 0, 0, 1, 2};

    repeat (3) @(negedge clk);
    #1 checkZeros("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mp_count_lit", 64'(mp_count), 64'd1023);

    applyStimulus(3'd0, 32'hA5A5_0000);
    applyStimulus(3'd1, 32'h5A5A_0001);
    applyStimulus(3'd2, 32'hC0DE_0002);
    applyStimulus(3'd3, 32'hBEEF_0003);
    applyStimulus(3'd4, 32'hDEAD_BEEF);
    applyStimulus(3'd5, 32'h1234_5678);
    applyStimulus(3'd6, 32'hFFFF_FFFF);
    applyStimulus(3'd7, 32'hEEEE_EEEE);
    @(negedge clk);
    checkOutput("mp_M_lit", mp_M, 64'h1234_5678_DEAD_BEEF);
    readWord(2'd2, 32'hC0DE_0002, "rd_addr2_lit");
    readWord(2'd3, 32'hBEEF_0003, "rd_addr3_lit");

    $display("[TB] e=101 e_len=3");
    runExp(16'b101, 3, 1'b0);
    checkOutput("t1_runs_lit", 64'(ops.size()), 64'd6);
    for (int i = 0; i < ops.size() && i < 6; i++)
      checkOutput($sformatf("t1_op%0d_lit", i), 64'(ops[i]), 64'(lit1[i]));

    $display("[TB] e_len=0");
    runExp(16'hBEEF, 0, 1'b0);
    checkOutput("t2_runs_lit", 64'(ops.size()), 64'd1);
    if (ops.size() > 0) checkOutput("t2_op_lit", 64'(ops[0]), 64'd2);

    $display("[TB] start and ld_en while busy");
    runExp(16'($urandom), 5, 1'b1);
    for (int a = 0; a < 4; a++) readWord(2'(a), shadow[a], "post_inject_ram");

    $display("[TB] e_len saturation");
    runExp(16'hFFFF, 25, 1'b0);
    checkOutput("sat_runs_lit", 64'(ops.size()), 64'd33);

    for (int r = 0; r < 3; r++) begin
      loadRandom();
      runExp(16'($urandom), $urandom_range(0, 20), 1'b0);
    end

    $display("[TB] reset during MUL_W");
    ops.delete();
    @(negedge clk);
    e     = 16'hFFFF;
    e_len = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (ops.size() < 2 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("mulw_reached", 64'(ops.size()), 64'd2);
    if (ops.size() > 1) checkOutput("mulw_op_lit", 64'(ops[1]), 64'd1);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkZeros("reset_mid");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_busy", 64'(busy), 64'd0);
    loadRandom();
    runExp(16'($urandom), 6, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
